// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: detects RAW hazards against in-flight producers and picks operand forward sources.
// Optional feature macro: DECODE_FORWARDING_EN (undefined = no bypass, consumers wait until the producer reaches W).
module decode_scoreboard #(
    parameter int STAGES   = 3,
    parameter int REG_BITS = 5,
    parameter int SEL_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] src1,
    input  logic [REG_BITS-1:0] src2,
    input  logic                src1_req,
    input  logic                src2_req,
    input  logic [REG_BITS-1:0] dst,
    input  logic                dst_wen,
    input  logic [SEL_BITS-1:0] rdy_at,
    input  logic                flush,
    output logic                out_valid,
    output logic [SEL_BITS-1:0] fwd1_sel,
    output logic [SEL_BITS-1:0] fwd2_sel,
    output logic                stall
);
    localparam logic [SEL_BITS-1:0] LAST_POS = SEL_BITS'(STAGES - 1);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] dst;
        logic [SEL_BITS-1:0] rdy_at;
    } entry_t;

    typedef struct packed {
        logic                hit;
        logic [SEL_BITS-1:0] pos;
        logic [SEL_BITS-1:0] rdy_at;
    } match_t;

    entry_t [STAGES-1:0] sb_r;
    entry_t              new_entry_s;
    match_t              m1_s;
    match_t              m2_s;
    logic                hazard_s;
    logic [SEL_BITS-1:0] sel1_s;
    logic [SEL_BITS-1:0] sel2_s;
    logic [SEL_BITS-1:0] rdy_clamp_s;

    // Scan oldest to youngest so the youngest matching producer is the one kept.
    function automatic match_t find_youngest(input logic [REG_BITS-1:0] src, input logic req,
                                             input entry_t [STAGES-1:0] sb);
        match_t m;
        m = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (req && (src != '0) && sb[k].valid && (sb[k].dst == src)) begin
                m.hit    = 1'b1;
                m.pos    = SEL_BITS'(k);
                m.rdy_at = sb[k].rdy_at;
            end
        end
        return m;
    endfunction

`ifdef DECODE_FORWARDING_EN
    function automatic logic hazard_of(input match_t m);
        return m.hit && (m.pos < m.rdy_at);
    endfunction

    // Position k forwards as select k+1; the W position is already in the register file.
    function automatic logic [SEL_BITS-1:0] sel_of(input match_t m);
        return (m.hit && (m.pos < LAST_POS)) ? (m.pos + SEL_BITS'(1)) : '0;
    endfunction
`else
    function automatic logic hazard_of(input match_t m);
        return m.hit && (m.pos < LAST_POS);
    endfunction

    logic unused_rdy_s;
    assign unused_rdy_s = ^{m1_s.rdy_at, m2_s.rdy_at};
`endif

    // Hazard detection and the issue handshake seen by decode.
    always_comb begin
        m1_s     = find_youngest(src1, src1_req, sb_r);
        m2_s     = find_youngest(src2, src2_req, sb_r);
        hazard_s = hazard_of(m1_s) | hazard_of(m2_s);
        stall    = in_valid & hazard_s;
        in_ready = in_valid & ~hazard_s & ~flush & ~reset;
    end

    // Forward selects and the entry that enters position 0 this cycle.
    always_comb begin
        if (rdy_at > LAST_POS) begin
            rdy_clamp_s = LAST_POS;
        end else begin
            rdy_clamp_s = rdy_at;
        end
`ifdef DECODE_FORWARDING_EN
        sel1_s = sel_of(m1_s);
        sel2_s = sel_of(m2_s);
`else
        sel1_s = '0;
        sel2_s = '0;
`endif
        new_entry_s = '0;
        if (in_ready && dst_wen && (dst != '0)) begin
            new_entry_s = '{valid: 1'b1, dst: dst, rdy_at: rdy_clamp_s};
        end else begin
            new_entry_s = '0;
        end
    end

    // Scoreboard shift (oldest entry retires to the register file) and registered issue outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_r      <= '0;
            out_valid <= 1'b0;
            fwd1_sel  <= '0;
            fwd2_sel  <= '0;
        end else begin
            sb_r      <= {sb_r[STAGES-2:0], new_entry_s};
            out_valid <= in_ready;
            fwd1_sel  <= in_ready ? sel1_s : '0;
            fwd2_sel  <= in_ready ? sel2_s : '0;
        end
    end
endmodule
